stage_wb: RTL and testbench
===========================

Name: stage_wb

Overview:
- Write-back stage: consumes the MM-to-WB bundle (reg_wr, reg_addr_rd, reg_data_rd, flush) and commits results into the architectural register file.
- Holds the register file with two asynchronous read ports for the ID stage.
- Provides a combinational forwarding tap for EX, a registered commit trace and a retired-instruction counter.
- It is the receiving end of the MM pipeline-register interface.

Parameters:
- DATA_W, `DATA_W (32): register and data width.
- REG_ADDR_W, `REG_ADDR_W (5): register address width.
- NUM_REGS, 2**REG_ADDR_W (32): number of architectural registers. Register 0 is hardwired to zero.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  core enable
- stall  in  1  WB stall; no commit while high
- flush  in  1  bundle invalid (bubble) when high
- reg_wr  in  1  bundle requests a register write
- reg_addr_rd  in  REG_ADDR_W  destination register
- reg_data_rd  in  DATA_W  write data
- rd_addr_a  in  REG_ADDR_W  read port A address
- rd_addr_b  in  REG_ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- fwd_valid  out  1  commit happening this cycle (combinational)
- fwd_addr  out  REG_ADDR_W  commit address (combinational)
- fwd_data  out  DATA_W  commit data (combinational)
- trc_valid  out  1  registered: commit occurred last cycle
- trc_addr  out  REG_ADDR_W  registered commit address
- trc_data  out  DATA_W  registered commit data
- retired  out  CNT_W  count of retired instructions

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- Reset state:
  - All NUM_REGS registers = 0.
  - trc_valid = 0, trc_addr = 0, trc_data = 0, retired = 0.
  - Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- advance = en && !stall && !flush.
- commit = advance && reg_wr && (reg_addr_rd != 0).
- On posedge clk with commit: regs[reg_addr_rd] <= reg_data_rd. Write latency is 1 cycle.
- No write to register 0, ever. A read of register 0 always returns 0, even with a bypass match.
- Read ports:
  - rd_data_x = (commit && rd_addr_x == reg_addr_rd) ? reg_data_rd : regs[rd_addr_x].
  - This write-through bypass means ID sees a value in the same cycle WB commits it.
  - Both ports bypass independently; both may match the same address.
- Forward tap: fwd_valid = commit, fwd_addr = reg_addr_rd, fwd_data = reg_data_rd. When fwd_valid = 0, fwd_addr and fwd_data are don't-care but must not be X.
- Trace:
  - Every posedge with en && !stall: trc_valid <= commit; trc_addr, trc_data <= the bundle values when commit, otherwise hold.
  - en=0 or stall=1: all trc_* hold.
- Retired counter:
  - retired <= retired + 1 on every posedge with advance, whether or not reg_wr is set (stores and branches count).
  - Wraps modulo 2**CNT_W without a flag.
- Stall: MM holds its bundle while stalled, so a held bundle commits exactly once, on the first non-stalled edge. No double count and no double trace.
- flush=1 with reg_wr=1: no write, no count, fwd_valid = 0.
- reg_wr=1 to register 0 with advance: no write, trc_valid = 0, retired increments.
- en=0: all state frozen; reads remain functional.

Decomposition:
- defines.vh (shared): DATA_W, REG_ADDR_W, and the register-0 address constant.
- Sub-module regfile_2r1w: storage array, async reset, one synchronous write port, two async read ports with write-through bypass and the register-0 rule.
- stage_wb holds the commit logic, forward tap, trace registers and counter.

Test Plan:
1. Reset release, read all 32 addresses on both ports -> every rd_data = 0, retired = 0, trc_valid = 0.
2. Bundle reg_wr=1, addr=5, data=0xDEADBEEF, flush=0, en=1, stall=0, with rd_addr_a=5:
   - Same cycle: rd_data_a = 0xDEADBEEF, fwd_valid = 1.
   - Next cycle: regs[5] = 0xDEADBEEF, trc_valid = 1, trc_addr = 5, retired = 1.
3. Same bundle held with stall=1 for 3 cycles, then stall=0 -> exactly one write, retired increments by 1 only, trc_valid pulses for a single cycle.
4. flush=1, reg_wr=1, addr=7, data=0x1234 -> regs[7] unchanged (0), retired unchanged, fwd_valid = 0.
5. reg_wr=1, addr=0, data=0xFFFFFFFF -> rd_data_a(addr 0) = 0, retired +1, trc_valid = 0.
6. Commit to addr=9 with data 0xA5A5A5A5 while the counter is preloaded near the top, then assert rst_n=0 between edges:
   - Counter 0xFFFFFFFF plus one advance -> retired wraps to 0.
   - Reset pulse -> outputs clear asynchronously and regs[9] reads 0.

Source files
------------

// File: rtl/stage_wb_pkg.sv
// Shared widths, the register-0 address and the commit-trace record for the write-back stage.
package stage_wb_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int RETIRED_W  = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_trace_t;

endpackage

// File: rtl/stage_wb_regfile_2r1w.sv
// Architectural register file: one synchronous write port, two combinational read ports
// with write-through bypass; entry 0 is a constant zero.
module regfile_2r1w
    import stage_wb_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    localparam int NR = 1 << AW;

    logic [DW-1:0] regs [NR];
    logic          we_eff;

    assign we_eff = we && (waddr != '0);

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_flop
                logic [DW-1:0] q_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (we_eff && (waddr == AW'(gi))) begin
                        q_reg <= wdata;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    // Register 0 wins over the bypass so a stray write to it can never leak through.
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we_eff && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we_eff && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: commits the MM bundle into the register file and exposes a forward tap,
// a registered commit trace and a retired-instruction counter.
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int CNT_W = RETIRED_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  reg_wr,
    input  logic [REG_ADDR_W-1:0] reg_addr_rd,
    input  logic [DATA_W-1:0]     reg_data_rd,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  trc_valid,
    output logic [REG_ADDR_W-1:0] trc_addr,
    output logic [DATA_W-1:0]     trc_data,
    output logic [CNT_W-1:0]      retired
);

    logic       advance;
    logic       commit;
    logic       step_en;
    wb_trace_t  trc_reg;
    logic [CNT_W-1:0] retired_reg;

    assign step_en = en && !stall;
    assign advance = step_en && !flush;
    assign commit  = advance && reg_wr && (reg_addr_rd != REG_ZERO);

    regfile_2r1w #(
        .DW (DATA_W),
        .AW (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (commit),
        .waddr   (reg_addr_rd),
        .wdata   (reg_data_rd),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rd_data_a),
        .rdata_b (rd_data_b)
    );

    assign fwd_valid = commit;
    assign fwd_addr  = reg_addr_rd;
    assign fwd_data  = reg_data_rd;

    // A stalled bundle is re-presented, so the trace only moves on non-stalled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trc_reg <= '0;
        end else if (step_en) begin
            trc_reg.valid <= commit;
            if (commit) begin
                trc_reg.addr <= reg_addr_rd;
                trc_reg.data <= reg_data_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_reg <= '0;
        end else if (advance) begin
            retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    assign trc_valid = trc_reg.valid;
    assign trc_addr  = trc_reg.addr;
    assign trc_data  = trc_reg.data;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_stage_wb.sv
// Bench for stage_wb: vector table plus hand sequences, checked against a bench-side model.
module tb_stage_wb;

    logic        clk;
    logic        rst_n;
    logic        en, stall, flush, reg_wr;
    logic [4:0]  reg_addr_rd, rd_addr_a, rd_addr_b;
    logic [31:0] reg_data_rd;
    logic [31:0] rd_data_a, rd_data_b, fwd_data, trc_data;
    logic [4:0]  fwd_addr, trc_addr;
    logic        fwd_valid, trc_valid;
    logic [31:0] retired;

    logic [31:0] w_rd_data_a, w_rd_data_b, w_fwd_data, w_trc_data;
    logic [4:0]  w_fwd_addr, w_trc_addr;
    logic        w_fwd_valid, w_trc_valid;
    logic [3:0]  w_retired;

    stage_wb u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
        .reg_wr(reg_wr), .reg_addr_rd(reg_addr_rd), .reg_data_rd(reg_data_rd),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .trc_valid(trc_valid), .trc_addr(trc_addr), .trc_data(trc_data),
        .retired(retired)
    );

    // Narrow-counter twin so the wrap boundary is reachable in a few cycles.
    stage_wb #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
        .reg_wr(reg_wr), .reg_addr_rd(reg_addr_rd), .reg_data_rd(reg_data_rd),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b),
        .fwd_valid(w_fwd_valid), .fwd_addr(w_fwd_addr), .fwd_data(w_fwd_data),
        .trc_valid(w_trc_valid), .trc_addr(w_trc_addr), .trc_data(w_trc_data),
        .retired(w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, stall, flush, wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  ra, rb;
        logic [31:0] exp_rda;
        logic        exp_fv;
        string       name;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } trc_exp_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_retired;
    logic        m_tv;
    logic [4:0]  m_ta;
    logic [31:0] m_td;
    trc_exp_t    sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_retired = '0;
        m_tv = 1'b0;
        m_ta = '0;
        m_td = '0;
        sb_q.delete();
    endtask

    // Called at a negedge; drives one bundle, checks comb outputs, then checks registered ones one edge later.
    task automatic step(input logic s_en, input logic s_stall, input logic s_flush, input logic s_wr,
                        input logic [4:0] s_addr, input logic [31:0] s_data,
                        input logic [4:0] s_ra, input logic [4:0] s_rb,
                        input bit have_exp, input logic [31:0] exp_rda, input logic exp_fv,
                        input string name);
        logic        m_commit;
        logic [31:0] e_rda, e_rdb;
        trc_exp_t    t;
        en = s_en; stall = s_stall; flush = s_flush; reg_wr = s_wr;
        reg_addr_rd = s_addr; reg_data_rd = s_data; rd_addr_a = s_ra; rd_addr_b = s_rb;
        #1;
        m_commit = s_en && !s_stall && !s_flush && s_wr && (s_addr != 5'd0);
        e_rda = (s_ra == 5'd0) ? 32'd0 : ((m_commit && s_ra == s_addr) ? s_data : m_regs[s_ra]);
        e_rdb = (s_rb == 5'd0) ? 32'd0 : ((m_commit && s_rb == s_addr) ? s_data : m_regs[s_rb]);
        if (have_exp) begin
            chk({name, ".tbl_rda"}, rd_data_a, exp_rda);
            chk({name, ".tbl_fv"}, {31'd0, fwd_valid}, {31'd0, exp_fv});
        end
        chk({name, ".rda"}, rd_data_a, e_rda);
        chk({name, ".rdb"}, rd_data_b, e_rdb);
        chk({name, ".fv"}, {31'd0, fwd_valid}, {31'd0, m_commit});
        if (m_commit) begin
            chk({name, ".fwd_addr"}, {27'd0, fwd_addr}, {27'd0, s_addr});
            chk({name, ".fwd_data"}, fwd_data, s_data);
        end
        if ($isunknown({fwd_addr, fwd_data})) chk({name, ".fwd_known"}, 32'd1, 32'd0);
        if (s_en && !s_stall) begin
            m_tv = m_commit;
            if (m_commit) begin
                m_ta = s_addr;
                m_td = s_data;
                t.addr = s_addr;
                t.data = s_data;
                sb_q.push_back(t);
            end
        end
        if (s_en && !s_stall && !s_flush) m_retired = m_retired + 32'd1;
        if (m_commit) m_regs[s_addr] = s_data;
        @(negedge clk);
        chk({name, ".trc_valid"}, {31'd0, trc_valid}, {31'd0, m_tv});
        chk({name, ".retired"}, retired, m_retired);
        chk({name, ".wrap_retired"}, {28'd0, w_retired}, {28'd0, m_retired[3:0]});
        if (s_en && !s_stall && trc_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk({name, ".trc_unexpected"}, 32'd1, 32'd0);
            end else begin
                t = sb_q.pop_front();
                chk({name, ".trc_addr"}, {27'd0, trc_addr}, {27'd0, t.addr});
                chk({name, ".trc_data"}, trc_data, t.data);
            end
        end
        chk({name, ".trc_addr_hold"}, {27'd0, trc_addr}, {27'd0, m_ta});
        chk({name, ".trc_data_hold"}, trc_data, m_td);
        $display("[TB] %s en=%0d stall=%0d flush=%0d wr=%0d addr=%0d data=%h rda=%h fv=%0d trc=%0d retired=%0d",
                 name, s_en, s_stall, s_flush, s_wr, s_addr, s_data, e_rda, m_commit, trc_valid, retired);
    endtask

    vec_t tbl [9];
    int   pulses;

    initial begin
        tbl[0] = '{1, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 1, "wr5"};
        tbl[1] = '{1, 0, 0, 0, 5'd5, 32'h00000000, 5'd5, 5'd5, 32'hDEADBEEF, 0, "rd5"};
        tbl[2] = '{1, 0, 1, 1, 5'd7, 32'h00001234, 5'd7, 5'd5, 32'h00000000, 0, "flush7"};
        tbl[3] = '{1, 0, 0, 0, 5'd7, 32'h00000000, 5'd7, 5'd0, 32'h00000000, 0, "rd7"};
        tbl[4] = '{1, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h00000000, 0, "wr0"};
        tbl[5] = '{0, 0, 0, 1, 5'd3, 32'h00000033, 5'd3, 5'd3, 32'h00000000, 0, "en_off"};
        tbl[6] = '{1, 0, 0, 1, 5'd3, 32'h00001111, 5'd3, 5'd3, 32'h00001111, 1, "wr3_both"};
        tbl[7] = '{1, 0, 0, 1, 5'd4, 32'h00004444, 5'd3, 5'd4, 32'h00001111, 1, "wr4"};
        tbl[8] = '{1, 0, 0, 0, 5'd4, 32'h00000000, 5'd4, 5'd3, 32'h00004444, 0, "rd4"};

        rst_n = 1'b0;
        en = 0; stall = 0; flush = 0; reg_wr = 0;
        reg_addr_rd = '0; reg_data_rd = '0; rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: every address on both ports reads zero.
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            chk($sformatf("rst_rda[%0d]", i), rd_data_a, 32'd0);
            chk($sformatf("rst_rdb[%0d]", 31 - i), rd_data_b, 32'd0);
        end
        chk("rst_retired", retired, 32'd0);
        chk("rst_trc_valid", {31'd0, trc_valid}, 32'd0);
        chk("rst_trc_data", trc_data, 32'd0);
        $display("[TB] reset scan of 32 registers done");
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].stall, tbl[i].flush, tbl[i].wr, tbl[i].addr, tbl[i].data,
                 tbl[i].ra, tbl[i].rb, 1'b1, tbl[i].exp_rda, tbl[i].exp_fv, tbl[i].name);
        end

        // Held bundle under stall commits once on release.
        begin
            logic [31:0] r0;
            r0 = retired;
            pulses = 0;
            for (int i = 0; i < 3; i++) begin
                step(1, 1, 0, 1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd12, 1'b1, 32'h0, 1'b0, "stall_hold");
                if (trc_valid) pulses++;
            end
            step(1, 0, 0, 1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd0, 1'b1, 32'hCAFEF00D, 1'b1, "stall_release");
            if (trc_valid) pulses++;
            step(1, 0, 1, 0, 5'd12, 32'h0, 5'd12, 5'd0, 1'b1, 32'hCAFEF00D, 1'b0, "post_stall_bubble");
            if (trc_valid) pulses++;
            chk("stall_retired_delta", retired - r0, 32'd1);
            chk("stall_trc_pulses", 32'(pulses), 32'd1);
        end

        // Commit to r9, then hit reset between edges.
        step(1, 0, 0, 1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 1'b1, 32'hA5A5A5A5, 1'b1, "wr9");
        step(1, 0, 0, 0, 5'd9, 32'h0, 5'd9, 5'd9, 1'b1, 32'hA5A5A5A5, 1'b0, "rd9");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd9", rd_data_a, 32'd0);
        chk("async_rst_retired", retired, 32'd0);
        chk("async_rst_trc_valid", {31'd0, trc_valid}, 32'd0);
        chk("async_rst_trc_addr", {27'd0, trc_addr}, 32'd0);
        chk("async_rst_trc_data", trc_data, 32'd0);
        $display("[TB] async reset asserted mid-cycle, rd9=%h retired=%0d", rd_data_a, retired);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap on the 4-bit twin: 15 advances, then one more.
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0, 5'd0, 32'h0, 5'd9, 5'd1, 1'b0, 32'h0, 1'b0, "count");
        end
        chk("wrap_preload", {28'd0, w_retired}, 32'd15);
        step(1, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd9, 1'b1, 32'h0, 1'b0, "wrap_step");
        chk("wrap_to_zero", {28'd0, w_retired}, 32'd0);
        chk("wrap_main_count", retired, 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
